// File: rtl/io_delay_pkg.sv
// rtl/io_delay_pkg.sv - shared types, tap constants and init-tap helper for io_delay_tuner
package io_delay_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2,
    OP_READ = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    S_WAIT_CAL,
    S_INIT,
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_RESP
  } state_e;

  localparam int TAP_PS_200 = 78;
  localparam int TAP_PS_400 = 39;
  localparam int MAX_TAPS   = 31;

  function automatic int calc_init_taps(input int cal_freq, input int init_delay);
    return init_delay / ((cal_freq == 400) ? TAP_PS_400 : TAP_PS_200);
  endfunction

endpackage

// File: rtl/io_delay_lane.sv
// rtl/io_delay_lane.sv - one delay lane: shadow tap count, load value and registered primitive pulses
module io_delay_lane #(
  parameter logic [4:0] INIT_TAPS = 5'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_ld,
  input  logic       load,
  input  logic       step,
  input  logic       step_up,
  input  logic [4:0] load_taps,
  output logic [4:0] shadow,
  output logic [4:0] cntvaluein,
  output logic       ld,
  output logic       ce,
  output logic       inc
);

  // Pulses are registered so every primitive control is exactly one clean cycle wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= INIT_TAPS;
      cntvaluein <= INIT_TAPS;
      ld         <= 1'b0;
      ce         <= 1'b0;
      inc        <= 1'b0;
    end else begin
      ld  <= init_ld | load;
      ce  <= step;
      inc <= step & step_up;
      if (init_ld) begin
        shadow     <= INIT_TAPS;
        cntvaluein <= INIT_TAPS;
      end else if (load) begin
        shadow     <= load_taps;
        cntvaluein <= load_taps;
      end else if (step) begin
        shadow <= step_up ? shadow + 5'd1 : shadow - 5'd1;
      end
    end
  end

endmodule

// File: rtl/io_delay_tuner.sv
// rtl/io_delay_tuner.sv - per-lane IDELAYE2 VAR_LOAD controller with shadow taps and command/response port
// Optional IODELAY_GLITCHLESS_EN: LOAD walks the tap count with single CE steps instead of an LD pulse.
module io_delay_tuner #(
  parameter int WIDTH         = 16,
  parameter int CAL_FREQ      = 200,
  parameter int INIT_DELAY    = 100,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cal_ready,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [4:0]         cmd_lane,
  input  logic [1:0]         cmd_op,
  input  logic [4:0]         cmd_taps,
  output logic               rsp_valid,
  output logic [4:0]         rsp_lane,
  output logic [4:0]         rsp_taps,
  output logic               rsp_err,
  output logic [WIDTH-1:0]   dly_ld,
  output logic [WIDTH-1:0]   dly_ce,
  output logic [WIDTH-1:0]   dly_inc,
  output logic [5*WIDTH-1:0] dly_cntvaluein
);
  import io_delay_pkg::*;

`ifdef IODELAY_GLITCHLESS_EN
  localparam bit GLITCHLESS = 1'b1;
`else
  localparam bit GLITCHLESS = 1'b0;
`endif

  localparam int         INIT_TAPS_I = calc_init_taps(CAL_FREQ, INIT_DELAY);
  localparam logic [4:0] INIT_TAPS   = 5'(INIT_TAPS_I);

  if (INIT_TAPS_I > MAX_TAPS) begin : g_bad_init
    $fatal(1, "io_delay_tuner: INIT_DELAY gives %0d taps, above %0d", INIT_TAPS_I, MAX_TAPS);
  end

  state_e     state, state_d;
  logic [4:0] lane_q, taps_q;
  cmd_op_e    op_q;
  logic       cmd_active;
  logic [3:0] cnt;
  logic       settle_done;

  logic       latch, init_stb, ld_stb, step_stb, step_up;
  logic [4:0] stb_lane, stb_taps;
  logic       rsp_set, rsp_err_d;
  logic [4:0] rsp_lane_d, rsp_taps_d;

  logic [4:0] shadow_w [WIDTH];
  logic [4:0] cmd_sh, lat_sh;
  logic       lane_ok;

  assign lane_ok     = ({27'd0, cmd_lane} < 32'(WIDTH));
  assign settle_done = (cnt == 4'(SETTLE_CYCLES - 1));
  assign cmd_ready   = (state == S_IDLE) && cal_ready;

  // Out-of-range lanes read back as zero taps.
  always_comb begin
    cmd_sh = 5'd0;
    lat_sh = 5'd0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cmd_lane == 5'(i)) cmd_sh = shadow_w[i];
      if (lane_q == 5'(i))   lat_sh = shadow_w[i];
    end
  end

  always_comb begin
    state_d    = state;
    latch      = 1'b0;
    init_stb   = 1'b0;
    ld_stb     = 1'b0;
    step_stb   = 1'b0;
    step_up    = 1'b0;
    stb_lane   = lane_q;
    stb_taps   = taps_q;
    rsp_set    = 1'b0;
    rsp_err_d  = 1'b0;
    rsp_lane_d = lane_q;
    rsp_taps_d = lat_sh;
    unique case (state)
      S_WAIT_CAL: begin
        if (cal_ready) begin
          init_stb = 1'b1;
          state_d  = S_INIT;
        end
      end
      S_INIT: state_d = cal_ready ? S_SETTLE : S_WAIT_CAL;
      S_IDLE: begin
        if (!cal_ready) begin
          state_d = S_WAIT_CAL;
        end else if (cmd_valid) begin
          latch      = 1'b1;
          stb_lane   = cmd_lane;
          stb_taps   = cmd_taps;
          rsp_lane_d = cmd_lane;
          rsp_taps_d = cmd_sh;
          rsp_set    = 1'b1;
          state_d    = S_RESP;
          if (!lane_ok) begin
            rsp_err_d = 1'b1;
          end else begin
            case (cmd_op_e'(cmd_op))
              OP_INC: begin
                if (cmd_sh == 5'(MAX_TAPS)) rsp_err_d = 1'b1;
                else begin step_stb = 1'b1; step_up = 1'b1; end
              end
              OP_DEC: begin
                if (cmd_sh == 5'd0) rsp_err_d = 1'b1;
                else step_stb = 1'b1;
              end
              OP_LOAD: begin
                if (!GLITCHLESS) ld_stb = 1'b1;
                else if (cmd_taps != cmd_sh) begin
                  step_stb = 1'b1;
                  step_up  = (cmd_taps > cmd_sh);
                end
              end
              default: ;
            endcase
          end
          if (step_stb || ld_stb) begin
            rsp_set = 1'b0;
            state_d = S_APPLY;
          end
        end
      end
      S_APPLY: begin
        if (!cal_ready) begin
          rsp_set   = 1'b1;
          rsp_err_d = 1'b1;
          state_d   = S_WAIT_CAL;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!cal_ready) begin
          rsp_set   = cmd_active;
          rsp_err_d = 1'b1;
          state_d   = S_WAIT_CAL;
        end else if (settle_done) begin
          if (!cmd_active) begin
            state_d = S_IDLE;
          end else if (GLITCHLESS && (op_q == OP_LOAD) && (lat_sh != taps_q)) begin
            step_stb = 1'b1;
            step_up  = (taps_q > lat_sh);
            state_d  = S_APPLY;
          end else begin
            rsp_set = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP:  state_d = cal_ready ? S_IDLE : S_WAIT_CAL;
      default: state_d = S_WAIT_CAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_WAIT_CAL;
      lane_q     <= 5'd0;
      op_q       <= OP_READ;
      taps_q     <= 5'd0;
      cmd_active <= 1'b0;
      cnt        <= 4'd0;
      rsp_valid  <= 1'b0;
      rsp_lane   <= 5'd0;
      rsp_taps   <= 5'd0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_d;
      if (latch) begin
        lane_q <= cmd_lane;
        op_q   <= cmd_op_e'(cmd_op);
        taps_q <= cmd_taps;
      end
      // Distinguishes a command's settle window from the post-INIT one.
      cmd_active <= ((state_d == S_APPLY) || (state_d == S_SETTLE)) && (cmd_active || latch);
      cnt        <= (state == S_SETTLE) ? cnt + 4'd1 : 4'd0;
      rsp_valid  <= rsp_set;
      if (rsp_set) begin
        rsp_lane <= rsp_lane_d;
        rsp_taps <= rsp_taps_d;
        rsp_err  <= rsp_err_d;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic sel;
    assign sel = (stb_lane == 5'(i));
    io_delay_lane #(.INIT_TAPS(INIT_TAPS)) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .init_ld    (init_stb),
      .load       (ld_stb & sel),
      .step       (step_stb & sel),
      .step_up    (step_up),
      .load_taps  (stb_taps),
      .shadow     (shadow_w[i]),
      .cntvaluein (dly_cntvaluein[5*i +: 5]),
      .ld         (dly_ld[i]),
      .ce         (dly_ce[i]),
      .inc        (dly_inc[i])
    );
  end

endmodule

// File: tb/tb_io_delay_tuner.sv
// tb/tb_io_delay_tuner.sv - table-driven, scoreboarded bench for io_delay_tuner
module tb_io_delay_tuner;
  localparam int W = 16;
  localparam int S = 4;
  localparam int INIT = 5;  // 400 ps / 78 ps
  localparam logic [1:0] LOAD = 2'd0, INC = 2'd1, DEC = 2'd2, READ = 2'd3;
`ifdef IODELAY_GLITCHLESS_EN
  localparam bit GL = 1'b1;
`else
  localparam bit GL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, cal_ready, cmd_valid, cmd_ready;
  logic [4:0] cmd_lane, cmd_taps, rsp_lane, rsp_taps;
  logic [1:0] cmd_op;
  logic rsp_valid, rsp_err;
  logic [W-1:0] dly_ld, dly_ce, dly_inc;
  logic [5*W-1:0] dly_cntvaluein;

  always #5 clk = ~clk;

  io_delay_tuner #(.WIDTH(W), .CAL_FREQ(200), .INIT_DELAY(400), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .cal_ready(cal_ready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_lane(cmd_lane), .cmd_op(cmd_op), .cmd_taps(cmd_taps),
    .rsp_valid(rsp_valid), .rsp_lane(rsp_lane), .rsp_taps(rsp_taps), .rsp_err(rsp_err),
    .dly_ld(dly_ld), .dly_ce(dly_ce), .dly_inc(dly_inc), .dly_cntvaluein(dly_cntvaluein)
  );

  typedef struct { int lane; int taps; int err; int cyc; } exp_t;
  typedef struct { int lane; logic [1:0] op; int taps; int exp_taps; int exp_err; } vec_t;

  exp_t sb[$];
  vec_t vecs[13];
  int model[W];
  int n_checks = 0, n_pass = 0, cyc = 0;
  int ld_cnt[W], ce_cnt[W];
  int ld_total, ce_total, inc_total, dec_total;
  int ce_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int cv(input int i);
    return int'(dly_cntvaluein[5*i +: 5]);
  endfunction

  task automatic clear_counts();
    for (int i = 0; i < W; i++) begin ld_cnt[i] = 0; ce_cnt[i] = 0; end
    ld_total = 0; ce_total = 0; inc_total = 0; dec_total = 0;
    ce_cyc.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < W; i++) begin
        if (dly_ld[i]) begin ld_cnt[i]++; ld_total++; end
        if (dly_ce[i]) begin
          ce_cnt[i]++; ce_total++;
          if (dly_inc[i]) inc_total++; else dec_total++;
          ce_cyc.push_back(cyc);
        end
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_lane", int'(rsp_lane), e.lane);
          check("rsp_taps", int'(rsp_taps), e.taps);
          check("rsp_err", int'(rsp_err), e.err);
          check("rsp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic send(input int lane, input logic [1:0] op, input int taps, output int n);
    int guard;
    guard = 0;
    cmd_valid = 1'b1; cmd_lane = 5'(lane); cmd_op = op; cmd_taps = 5'(taps);
    @(negedge clk);
    while (!cmd_ready && guard < 200) begin @(negedge clk); guard++; end
    if (!cmd_ready) check("send_timeout", 0, 1);
    n = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_sb(input string name);
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 400) begin @(negedge clk); guard++; end
    if (sb.size() != 0) begin check(name, 0, 1); sb.delete(); end
    @(posedge clk); #1;
  endtask

  task automatic bring_up(input string name);
    int k, guard, ok;
    clear_counts();
    cal_ready = 1'b1;
    k = cyc;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    check({name, "_ready_cycle"}, cyc, k + 2 + S);
    check({name, "_ld_total"}, ld_total, W);
    ok = 0;
    for (int i = 0; i < W; i++) if (ld_cnt[i] == 1 && cv(i) == INIT) ok++;
    check({name, "_lanes_reloaded"}, ok, W);
    check({name, "_ce_total"}, ce_total, 0);
    for (int i = 0; i < W; i++) model[i] = INIT;
    @(posedge clk); #1;
  endtask

  task automatic read_check(input int lane);
    int n;
    send(lane, READ, 0, n);
    sb.push_back('{lane, model[lane], 0, n + 1});
    wait_sb("read_wait");
  endtask

  initial begin
    int n, prev, d, lat, eld, ece, einc, drop, ok;
    vecs[0]  = '{3,  READ, 0,  5,  0};
    vecs[1]  = '{2,  LOAD, 17, 17, 0};
    vecs[2]  = '{2,  READ, 0,  17, 0};
    vecs[3]  = '{2,  INC,  0,  18, 0};
    vecs[4]  = '{7,  DEC,  0,  4,  0};
    vecs[5]  = '{0,  LOAD, 31, 31, 0};
    vecs[6]  = '{0,  INC,  0,  31, 1};
    vecs[7]  = '{0,  LOAD, 0,  0,  0};
    vecs[8]  = '{0,  DEC,  0,  0,  1};
    vecs[9]  = '{20, READ, 0,  0,  1};
    vecs[10] = '{20, INC,  0,  0,  1};
    vecs[11] = '{15, LOAD, 5,  5,  0};
    vecs[12] = '{20, LOAD, 3,  0,  1};

    rst_n = 1'b0; cal_ready = 1'b0; cmd_valid = 1'b0;
    cmd_lane = 5'd0; cmd_op = 2'd0; cmd_taps = 5'd0;
    clear_counts();
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", int'(cmd_ready), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_taps", int'(rsp_taps), 0);
    check("rst_dly_ld", int'(dly_ld), 0);
    ok = 0;
    for (int i = 0; i < W; i++) if (cv(i) == INIT) ok++;
    check("rst_cntvaluein", ok, W);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("nocal_cmd_ready", int'(cmd_ready), 0);
    @(posedge clk); #1;
    bring_up("boot");

    foreach (vecs[v]) begin
      clear_counts();
      prev = (vecs[v].lane < W) ? model[vecs[v].lane] : 0;
      d = vecs[v].exp_taps - prev;
      einc = (d > 0) ? 1 : 0;
      if (d < 0) d = -d;
      eld = 0; ece = 0;
      if (vecs[v].exp_err != 0 || vecs[v].op == READ) lat = 1;
      else if (vecs[v].op == LOAD) begin
        if (GL) begin lat = (d == 0) ? 1 : 1 + d * (1 + S); ece = d; end
        else begin lat = 2 + S; eld = 1; end
      end else begin
        lat = 2 + S; ece = 1; einc = (vecs[v].op == INC) ? 1 : 0;
      end
      send(vecs[v].lane, vecs[v].op, vecs[v].taps, n);
      sb.push_back('{vecs[v].lane, vecs[v].exp_taps, vecs[v].exp_err, n + lat});
      wait_sb("vec_wait");
      check("vec_ld_total", ld_total, eld);
      check("vec_ce_total", ce_total, ece);
      check("vec_inc_total", inc_total, (ece > 0 && einc != 0) ? ece : 0);
      if (vecs[v].lane < W) begin
        check("vec_lane_pulses", ld_cnt[vecs[v].lane] + ce_cnt[vecs[v].lane], eld + ece);
        if (vecs[v].exp_err == 0) model[vecs[v].lane] = vecs[v].exp_taps;
      end
`ifndef IODELAY_GLITCHLESS_EN
      if (vecs[v].op == LOAD && vecs[v].exp_err == 0) check("vec_cntvaluein", cv(vecs[v].lane), vecs[v].exp_taps);
`endif
    end

`ifndef IODELAY_GLITCHLESS_EN
    clear_counts();
    send(2, LOAD, 9, n);
    sb.push_back('{2, 9, 0, n + 2 + S});
    @(negedge clk);
    check("ld2_cntvaluein_n1", cv(2), 9);
    check("ld2_pulse_n1", int'(dly_ld[2]), 1);
    check("ld2_cmd_ready_n1", int'(cmd_ready), 0);
    @(negedge clk);
    check("ld2_pulse_n2", int'(dly_ld[2]), 0);
    check("ld2_cntvaluein_n2", cv(2), 9);
    wait_sb("ld2_wait");
    check("ld2_ld_total", ld_total, 1);
    model[2] = 9;
`endif

    send(1, INC, 0, n);
    @(posedge clk); #1;
    @(posedge clk); #1;
    cal_ready = 1'b0;
    drop = cyc;
    sb.push_back('{1, model[1] + 1, 1, drop + 1});
    cmd_valid = 1'b1; cmd_lane = 5'd3; cmd_op = READ;
    repeat (3) @(negedge clk);
    check("nocal_ignores_cmd", int'(cmd_ready), 0);
    wait_sb("abort_wait");
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    bring_up("recal");
    read_check(1);
    read_check(2);

`ifdef IODELAY_GLITCHLESS_EN
    clear_counts();
    send(4, LOAD, 2, n);
    sb.push_back('{4, 2, 0, n + 1 + 3 * (1 + S)});
    wait_sb("walk_wait");
    check("walk_ce_lane4", ce_cnt[4], 3);
    check("walk_dec_total", dec_total, 3);
    check("walk_ld_total", ld_total, 0);
    check("walk_ce_count", ce_cyc.size(), 3);
    if (ce_cyc.size() == 3) begin
      check("walk_first_pulse", ce_cyc[0], n + 1);
      check("walk_spacing_1", ce_cyc[1] - ce_cyc[0], 1 + S);
      check("walk_spacing_2", ce_cyc[2] - ce_cyc[1], 1 + S);
    end
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
